// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter for N requesters with a one-hot rotating priority pointer.
// A grant is held while its owner keeps requesting, up to MAX_HOLD cycles.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4,
  parameter int ID_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_vld,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]     PTR_INIT  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     ZERO_N    = {N{1'b0}};

  state_t           state_r;
  logic [N-1:0]     ptr_r;
  logic [CNT_W-1:0] hold_cnt_r;

  logic [N-1:0]     ptr_eff_s;
  logic [N-1:0]     winner_s;
  logic             owner_req_s;
  logic             at_limit_s;

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != ZERO_N) && ((v & (v - N'(1))) == ZERO_N);
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  function automatic logic [ID_W-1:0] to_index(input logic [N-1:0] v);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest one.
  function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] r_hi;
    logic [N-1:0] src;
    r_hi = r & ~(p - N'(1));
    if (r_hi != ZERO_N) begin
      src = r_hi;
    end else begin
      src = r;
    end
    return src & (~src + N'(1));
  endfunction

  // Sanitised pointer, arbitration winner and owner status for the current cycle.
  always_comb begin
    if (is_onehot(ptr_r)) begin
      ptr_eff_s = ptr_r;
    end else begin
      ptr_eff_s = PTR_INIT;
    end
    winner_s    = pick(req, ptr_eff_s);
    owner_req_s = |(req & grant);
    at_limit_s  = (hold_cnt_r == HOLD_LAST);
  end

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= PTR_INIT;
      hold_cnt_r <= {CNT_W{1'b0}};
      grant      <= ZERO_N;
      grant_vld  <= 1'b0;
      grant_id   <= {ID_W{1'b0}};
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      ptr_r   <= ptr_eff_s;
      case (state_r)
        IDLE: begin
          if (req != ZERO_N) begin
            grant      <= winner_s;
            grant_vld  <= 1'b1;
            grant_id   <= to_index(winner_s);
            hold_cnt_r <= {CNT_W{1'b0}};
            state_r    <= BUSY;
          end else begin
            grant      <= ZERO_N;
            grant_vld  <= 1'b0;
            grant_id   <= {ID_W{1'b0}};
            hold_cnt_r <= {CNT_W{1'b0}};
            state_r    <= IDLE;
          end
        end
        BUSY: begin
          if (!owner_req_s || at_limit_s) begin
            // A voluntary drop on the limit cycle is an ordinary release, not a timeout.
            grant      <= ZERO_N;
            grant_vld  <= 1'b0;
            grant_id   <= {ID_W{1'b0}};
            hold_cnt_r <= {CNT_W{1'b0}};
            timeout    <= owner_req_s;
            state_r    <= IDLE;
            if (is_onehot(grant)) begin
              ptr_r <= rotl(grant);
            end else begin
              ptr_r <= PTR_INIT;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
            state_r    <= BUSY;
          end
        end
        default: begin
          grant      <= ZERO_N;
          grant_vld  <= 1'b0;
          grant_id   <= {ID_W{1'b0}};
          hold_cnt_r <= {CNT_W{1'b0}};
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
